// File: rtl/prog_loader.sv
// Program-memory loader: receives a length-framed, checksummed byte stream and
// writes it into program memory while holding the processor in reset.
module prog_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // state  | meaning
    // IDLE   | after reset, processor free, nothing loaded
    // LEN_HI | waiting for length high byte (upper nibble must be zero)
    // LEN_LO | waiting for length low byte
    // DATA   | streaming data bytes into program memory
    // CHK    | waiting for the checksum byte
    // DONE   | load good, processor released
    // ERR    | load aborted, processor kept in reset
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] n_len;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sum;
    logic              xfer;
    logic              len_hi_bad;
    logic              last_byte;
    logic              len_zero;

    // Status and handshake decode only the state register, never byte_valid.
    assign byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                        (state == S_DATA)   || (state == S_CHK);
    assign cpu_hold   = byte_ready || (state == S_ERR);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERR);

    assign xfer       = byte_valid && byte_ready;
    assign len_hi_bad = (byte_in[DATA_W-1:ADDR_W-DATA_W] != '0);
    assign last_byte  = (addr == n_len - ADDR_W'(1));
    assign len_zero   = ({n_len[ADDR_W-1:DATA_W], byte_in} == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LEN_HI;
            S_LEN_HI: if (xfer)  state_nx = len_hi_bad ? S_ERR : S_LEN_LO;
            S_LEN_LO: if (xfer)  state_nx = len_zero ? S_CHK : S_DATA;
            S_DATA:   if (xfer && last_byte) state_nx = S_CHK;
            S_CHK:    if (xfer)  state_nx = (byte_in == sum) ? S_DONE : S_ERR;
            S_DONE:   if (start) state_nx = S_LEN_HI;
            S_ERR:    if (start) state_nx = S_LEN_HI;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Write port is registered: a byte accepted in cycle t is written in t+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_len    <= '0;
            addr     <= '0;
            sum      <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_we <= 1'b0;
            if (xfer) begin
                case (state)
                    S_LEN_HI: begin
                        if (!len_hi_bad)
                            n_len[ADDR_W-1:DATA_W] <= byte_in[ADDR_W-DATA_W-1:0];
                    end
                    S_LEN_LO: begin
                        n_len[DATA_W-1:0] <= byte_in;
                        addr              <= '0;
                        sum               <= '0;
                    end
                    S_DATA: begin
                        sum      <= sum + byte_in;
                        mem_we   <= 1'b1;
                        mem_addr <= addr;
                        mem_data <= byte_in;
                        addr     <= addr + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory loader for the 4-bit processor. It receives a framed byte stream over a valid/ready handshake and writes it into the 4096 × 8 program memory that the program counter fetches from. It holds the processor in reset while loading. It checks the frame length and an 8-bit checksum, and reports done or error. The block sits between the external byte source and the write port of the program memory; the processor's read path is untouched.

## Interface
- ADDR_W, 12, program-memory address width (matches the PC width)
- DATA_W, 8, program-byte width (matches the program_byte width)
- clock  in  1  single system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; forces IDLE on the next rising edge
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE and ERR
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in is valid this cycle
- byte_ready  out  1  loader accepts byte_in this cycle
- mem_we  out  1  program-memory write strobe, one cycle per data byte
- mem_addr  out  12  write address
- mem_data  out  8  write data
- cpu_hold  out  1  drive into the processor reset; high while loading and in ERR
- done  out  1  load completed with a good checksum (level)
- error  out  1  load aborted (level)

## Operation
- Frame format: LEN_HI, LEN_LO, N data bytes, CHK.
  - LEN_HI[3:0] gives N[11:8]; LEN_LO gives N[7:0].
  - CHK equals the sum mod 256 of the data bytes.
- A transfer occurs in a cycle where byte_valid and byte_ready are both 1. No other cycle consumes a byte.
- States and transitions:
  - IDLE: ready=0, hold=0. Goes to LEN_HI on start.
  - LEN_HI: ready=1, hold=1. On transfer, goes to ERR if byte_in[7:4]≠0; otherwise latches N[11:8] and goes to LEN_LO.
  - LEN_LO: ready=1, hold=1. On transfer, latches N[7:0], clears the address counter and the sum, then goes to DATA if N≠0, or to CHK if N=0.
  - DATA: ready=1, hold=1. On transfer:
    - sum ← sum+byte_in (8-bit wrap);
    - issue a write at the current address;
    - increment the address;
    - after the N-th byte, go to CHK.
  - CHK: ready=1, hold=1. On transfer, goes to DONE if byte_in==sum, else to ERR.
  - DONE: ready=0, done=1, hold=0. Goes to LEN_HI on start.
  - ERR: ready=0, error=1, hold=1. Goes to LEN_HI on start.
- Starting a new load from DONE or ERR clears done and error on entry to LEN_HI.
- start is ignored in LEN_HI, LEN_LO, DATA and CHK.
- Address counter:
  - It is 12 bits.
  - The first data byte goes to address 0.
  - N=4095 writes addresses 0..4094. The counter never wraps within a frame.
- Data bytes are written in stream order. There is no skip and no reorder.
- Reset in any state, including mid-DATA, returns the block to IDLE.
  - Bytes already written stay in memory.
  - Reset does not raise error.

## Timing
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=0, done=0, error=0. Internal N, sum and address are 0.
- byte_ready is a registered function of state only. It never depends combinationally on byte_valid.
- Write latency:
  - A data byte transferred in cycle t produces mem_we=1 in cycle t+1, with mem_addr and mem_data holding that byte's address and value.
  - mem_we=0 in every other cycle.
  - mem_addr and mem_data hold their last value between writes.
- Throughput: one byte per cycle sustained; back-to-back transfers are allowed.
- byte_valid may drop at any time without penalty. The state holds until the next transfer.
- The last data write (cycle t+1) can coincide with the CHK transfer. Both must complete.
- Status timing: done or error rises in the cycle after the CHK transfer, or after the bad LEN_HI transfer.
- cpu_hold timing:
  - It rises in the cycle after start is sampled.
  - It falls in the same cycle done rises.
- start in the same cycle as reset: reset wins.

## Test plan
- Frame 00,03,A1,B2,C3,16 sent one byte per cycle → writes (0,A1), (1,B2), (2,C3) on consecutive cycles; done=1 one cycle after the last byte; cpu_hold 1→0.
- Same frame with CHK=17 → all three writes happen; error=1; done=0; cpu_hold stays 1 until the next start.
- Frame 00,00,00 (N=0) → no mem_we; done=1. First byte 10 → error=1 immediately; no writes.
- Frame 0F,FF followed by 4095 bytes of 01 and CHK=FF → last write at address FFE; no write at FFF; done=1.
- byte_valid toggling 1,0,0,1 during DATA → exactly one write per accepted byte; addresses contiguous; no stalled-cycle writes.
- Reset asserted after 2 of 5 data bytes → next cycle state IDLE with all outputs at reset values; later frame 00,01,5A,5A → write (0,5A) and done=1.
